// File: rtl/fetch_unit.sv
// fetch_unit: PC owner driving instruction memory into an IF/ID register (ports: clk, reset, imem_addr/imem_instr, redirect/redirect_pc, id_ready, id_valid/id_instr/id_pc/id_pc_plus4, halted, fetch_count)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PROG_END = 32'd20,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc_plus4,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);
  localparam logic [1:0] WARM = 2'd0, FETCH = 2'd1, STALL = 2'd2, HALT = 2'd3;
  logic [1:0] state;
  logic [31:0] pc;
  logic at_end, take;
  assign imem_addr = pc;
  assign at_end = pc >= PROG_END;
  assign take = (state == FETCH || state == STALL) && !at_end && (!id_valid || id_ready);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      state <= WARM;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc <= '0;
      id_pc_plus4 <= '0;
      halted <= 1'b0;
      fetch_count <= '0;
    end else if (redirect && state != WARM) begin
      pc <= {redirect_pc[31:2], 2'b00};
      id_valid <= 1'b0;
      halted <= 1'b0;
      state <= WARM;
    end else if (state == WARM) begin
      state <= FETCH;
    end else if (take) begin
      id_instr <= imem_instr;
      id_pc <= pc;
      id_pc_plus4 <= pc + 32'd4;
      id_valid <= 1'b1;
      pc <= pc + 32'd4;
      fetch_count <= fetch_count + {{(CNT_W-1){1'b0}}, ~&fetch_count};
      state <= FETCH;
    end else begin
      // not capturing: the held word leaves IF/ID once the decoder takes it
      if (id_ready) id_valid <= 1'b0;
      if (at_end) begin
        state <= HALT;
        halted <= 1'b1;
      end else begin
        state <= STALL;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a behavioural model
module tb_fetch_unit;
  localparam int CW = 4;
  logic clk = 1'b0, reset = 1'b1, redirect = 1'b0, id_ready = 1'b1;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_instr, id_instr, id_pc, id_pc_plus4;
  logic id_valid, halted;
  logic [CW-1:0] fetch_count;
  int nchk = 0, nerr = 0;

  fetch_unit #(.RESET_PC(32'd0), .PROG_END(32'd20), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h13;
  endfunction
  assign imem_instr = mem(imem_addr);

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #3;
    nchk++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", id_valid); end
    nchk++; if (imem_addr !== 32'd0) begin nerr++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
    nchk++; if ({halted, fetch_count} !== '0) begin nerr++; $display("FAIL reset_halt_cnt got %b/%0d want 0/0", halted, fetch_count); end
    nchk++; if ({id_instr, id_pc, id_pc_plus4} !== '0) begin nerr++; $display("FAIL reset_ifid got %h/%h/%h want 0", id_instr, id_pc, id_pc_plus4); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_stream;
    tick;
    nchk++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL warm_valid got %b want 0", id_valid); end
    for (int i = 0; i < 5; i++) begin
      tick;
      nchk++; if (id_valid !== 1'b1 || id_pc !== 32'(4*i) || id_instr !== mem(32'(4*i)))
        begin nerr++; $display("FAIL stream%0d got v=%b pc=%0d ins=%h want v=1 pc=%0d ins=%h", i, id_valid, id_pc, id_instr, 4*i, mem(32'(4*i))); end
    end
    nchk++; if (imem_addr !== 32'd20) begin nerr++; $display("FAIL stream_end_addr got %0d want 20", imem_addr); end
    tick;
    nchk++; if (halted !== 1'b1 || id_valid !== 1'b0 || fetch_count !== 4'd5)
      begin nerr++; $display("FAIL halt got h=%b v=%b cnt=%0d want h=1 v=0 cnt=5", halted, id_valid, fetch_count); end
    tick;
    nchk++; if (halted !== 1'b1 || imem_addr !== 32'd20 || fetch_count !== 4'd5)
      begin nerr++; $display("FAIL halt_hold got h=%b addr=%0d cnt=%0d want 1/20/5", halted, imem_addr, fetch_count); end
  endtask

  task automatic test_halt_redirect;
    redirect = 1'b1; redirect_pc = 32'd0;
    tick;
    redirect = 1'b0;
    nchk++; if (halted !== 1'b0 || id_valid !== 1'b0 || imem_addr !== 32'd0)
      begin nerr++; $display("FAIL halt_redir got h=%b v=%b addr=%0d want 0/0/0", halted, id_valid, imem_addr); end
    tick;
    nchk++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL halt_redir_warm got %b want 0", id_valid); end
    tick;
    nchk++; if (id_valid !== 1'b1 || id_pc !== 32'd0 || fetch_count !== 4'd6)
      begin nerr++; $display("FAIL halt_restart got v=%b pc=%0d cnt=%0d want 1/0/6", id_valid, id_pc, fetch_count); end
  endtask

  task automatic test_stall;
    tick; tick;
    nchk++; if (id_pc !== 32'd8 || imem_addr !== 32'd12) begin nerr++; $display("FAIL pre_stall got pc=%0d addr=%0d want 8/12", id_pc, imem_addr); end
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      nchk++; if (id_valid !== 1'b1 || id_pc !== 32'd8 || id_instr !== mem(32'd8) || imem_addr !== 32'd12)
        begin nerr++; $display("FAIL stall%0d got v=%b pc=%0d ins=%h addr=%0d want 1/8/%h/12", i, id_valid, id_pc, id_instr, imem_addr, mem(32'd8)); end
    end
    id_ready = 1'b1;
    tick;
    nchk++; if (id_valid !== 1'b1 || id_pc !== 32'd12) begin nerr++; $display("FAIL stall_resume got v=%b pc=%0d want 1/12", id_valid, id_pc); end
  endtask

  task automatic test_redirect;
    redirect = 1'b1; redirect_pc = 32'd16;
    tick;
    redirect = 1'b0;
    nchk++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL redir_flush got %b want 0", id_valid); end
    tick;
    nchk++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL redir_warm got %b want 0", id_valid); end
    tick;
    nchk++; if (id_valid !== 1'b1 || id_pc !== 32'd16 || id_pc_plus4 !== 32'd20)
      begin nerr++; $display("FAIL redir_target got v=%b pc=%0d p4=%0d want 1/16/20", id_valid, id_pc, id_pc_plus4); end
  endtask

  task automatic test_align;
    redirect = 1'b1; redirect_pc = 32'd6;
    tick;
    nchk++; if (imem_addr !== 32'd4) begin nerr++; $display("FAIL align got %0d want 4", imem_addr); end
    redirect_pc = 32'd12;
    tick;
    redirect = 1'b0;
    nchk++; if (imem_addr !== 32'd4) begin nerr++; $display("FAIL warm_ignore got %0d want 4", imem_addr); end
    tick;
    nchk++; if (id_valid !== 1'b1 || id_pc !== 32'd4) begin nerr++; $display("FAIL align_fetch got v=%b pc=%0d want 1/4", id_valid, id_pc); end
  endtask

  task automatic test_async_reset;
    id_ready = 1'b0;
    tick; tick;
    #2 reset = 1'b1;
    #1;
    nchk++; if (id_valid !== 1'b0 || imem_addr !== 32'd0 || halted !== 1'b0 || fetch_count !== '0 || {id_instr, id_pc, id_pc_plus4} !== '0)
      begin nerr++; $display("FAIL async_reset got v=%b addr=%0d cnt=%0d pc=%0d want all zero", id_valid, imem_addr, fetch_count, id_pc); end
    @(negedge clk);
    id_ready = 1'b1;
    reset = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] m_pc = 0, m_instr = 0, m_idpc = 0;
    logic m_warm = 1, m_halt = 0, m_v = 0;
    int m_cnt = 0;
    for (int c = 0; c < 800; c++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 27));
      if (redirect && !m_warm) begin
        m_pc = redirect_pc & ~32'd3; m_v = 0; m_halt = 0; m_warm = 1;
      end else if (m_warm) m_warm = 0;
      else if (m_pc >= 32'd20) begin
        m_halt = 1; if (id_ready) m_v = 0;
      end else if (!m_v || id_ready) begin
        m_instr = mem(m_pc); m_idpc = m_pc; m_v = 1; m_pc = m_pc + 4;
        if (m_cnt < 15) m_cnt++;
      end
      tick;
      nchk++; if (id_valid !== m_v || imem_addr !== m_pc || halted !== m_halt || fetch_count !== CW'(m_cnt))
        begin nerr++; $display("FAIL rand%0d ctrl got v=%b addr=%h h=%b cnt=%0d want v=%b addr=%h h=%b cnt=%0d", c, id_valid, imem_addr, halted, fetch_count, m_v, m_pc, m_halt, m_cnt); end
      if (m_v) begin
        nchk++; if (id_pc !== m_idpc || id_instr !== m_instr || id_pc_plus4 !== m_idpc + 32'd4)
          begin nerr++; $display("FAIL rand%0d ifid got pc=%h ins=%h p4=%h want pc=%h ins=%h p4=%h", c, id_pc, id_instr, id_pc_plus4, m_idpc, m_instr, m_idpc + 32'd4); end
      end
    end
    redirect = 1'b0;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_halt_redirect;
    test_stall;
    test_redirect;
    test_align;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
